// File: rtl/atari7800_pkg.sv
// Shared MARIA constants: register window offsets, reset values and the colour offset map.
package atari7800_pkg;

   localparam logic [4:0] OFF_BACKGRND = 5'h00;
   localparam logic [4:0] OFF_WSYNC    = 5'h04;
   localparam logic [4:0] OFF_MSTAT    = 5'h08;
   localparam logic [4:0] OFF_DPPH     = 5'h0C;
   localparam logic [4:0] OFF_DPPL     = 5'h10;
   localparam logic [4:0] OFF_CHARBASE = 5'h14;
   localparam logic [4:0] OFF_CTRL     = 5'h1C;

   localparam logic [7:0]  CTRL_RESET     = 8'h70;
   localparam logic [15:0] ZP_BYPASS_NTSC = 16'h0084;
   localparam logic [15:0] ZP_BYPASS_PAL  = 16'h2730;

   typedef enum logic {
      WS_IDLE = 1'b0,
      WS_WAIT = 1'b1
   } wsync_state_t;

   // Colour index 1+3p+c lives at window offset 4p+c+1; index 0 is BACKGRND.
   function automatic logic [4:0] color_offset(input int idx);
      if (idx == 0) begin
         return OFF_BACKGRND;
      end
      return 5'(4 * ((idx - 1) / 3) + ((idx - 1) % 3) + 1);
   endfunction

endpackage

// File: rtl/maria_wsync_fsm.sv
// WSYNC hold: drops ready on a WSYNC write until the next line start or a saturating timeout.
module maria_wsync_fsm
   import atari7800_pkg::*;
#(
   parameter int WSYNC_MAX = 1023
) (
   input  logic clk_sys,
   input  logic srst,
   input  logic wsync_wr,
   input  logic line_start,
   output logic ready
);

   localparam int CNT_W = (WSYNC_MAX < 1) ? 1 : $clog2(WSYNC_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WSYNC_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WSYNC_MAX > 0) ? WSYNC_MAX - 1 : 0);

   wsync_state_t     state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             ready_reg;

   always_ff @(posedge clk_sys) begin
      if (srst) begin
         state_reg <= WS_IDLE;
         cnt_reg   <= '0;
         ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            WS_IDLE: begin
               // A line_start in the same cycle as the write is deliberately not honoured.
               if (wsync_wr) begin
                  state_reg <= WS_WAIT;
                  cnt_reg   <= '0;
                  ready_reg <= 1'b0;
               end
            end
            WS_WAIT: begin
               if (cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
               if (line_start || (cnt_reg >= CNT_LAST)) begin
                  state_reg <= WS_IDLE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= WS_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_reg;

endmodule

// File: rtl/maria_regbank.sv
// MARIA register bank: CPU decode of the register window, palette/control/DPP storage,
// optional line-synchronous shadow commit, optional readback and the WSYNC ready hold.
module maria_regbank
   import atari7800_pkg::*;
#(
   parameter int  N_PAL     = 8,
   parameter int  SHADOW    = 0,
   parameter int  READBACK  = 0,
   parameter int  WSYNC_MAX = 1023,
   localparam int N_COLOR   = 1 + 3 * N_PAL
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        maria_en,
   input  logic        bypass_bios,
   input  logic        pal,
   input  logic        pclk0,
   input  logic        cs_maria,
   input  logic [4:0]  AB,
   input  logic        RW,
   input  logic [7:0]  DB_in,
   output logic [7:0]  DB_out,
   input  logic [7:0]  status_read,
   input  logic        line_start,
   output logic        ready,
   output logic [7:0]  ctrl,
   output logic [7:0]  char_base,
   output logic [15:0] ZP,
   output logic [7:0]  color_map [N_COLOR]
);

   logic        srst;
   logic        wr_stb;
   logic        rd_stb;
   logic [15:0] zp_reset;

   logic [7:0]  color_reg [N_COLOR];
   logic [7:0]  color_shd [N_COLOR];
   logic [7:0]  ctrl_reg;
   logic [7:0]  ctrl_shd;
   logic [7:0]  charbase_reg;
   logic [7:0]  charbase_shd;
   logic [7:0]  dpph_reg;
   logic [7:0]  dppl_reg;
   logic [7:0]  db_out_reg;
   logic [7:0]  rd_data_next;

   logic [N_COLOR-1:0] color_hit;
   logic        ctrl_hit;
   logic        charbase_hit;
   logic        dpph_hit;
   logic        dppl_hit;
   logic        wsync_hit;

   assign srst     = reset | ~maria_en;
   assign wr_stb   = pclk0 & cs_maria & ~RW;
   assign rd_stb   = pclk0 & cs_maria & RW;
   assign zp_reset = bypass_bios ? (pal ? ZP_BYPASS_PAL : ZP_BYPASS_NTSC) : 16'h0000;

   assign ctrl_hit     = wr_stb && (AB == OFF_CTRL);
   assign charbase_hit = wr_stb && (AB == OFF_CHARBASE);
   assign dpph_hit     = wr_stb && (AB == OFF_DPPH);
   assign dppl_hit     = wr_stb && (AB == OFF_DPPL);
   assign wsync_hit    = wr_stb && (AB == OFF_WSYNC);

   // Only palettes below N_PAL get a decoder, so writes above them fall through.
   generate
      for (genvar gi = 0; gi < N_COLOR; gi++) begin : g_color
         localparam logic [4:0] COLOR_OFF = color_offset(gi);
         assign color_hit[gi] = wr_stb && (AB == COLOR_OFF);
         assign color_map[gi] = color_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk_sys) begin
      if (srst) begin
         for (int i = 0; i < N_COLOR; i++) begin
            color_reg[i] <= '0;
            color_shd[i] <= '0;
         end
         ctrl_reg     <= CTRL_RESET;
         ctrl_shd     <= CTRL_RESET;
         charbase_reg <= '0;
         charbase_shd <= '0;
         dpph_reg     <= zp_reset[15:8];
         dppl_reg     <= zp_reset[7:0];
      end else begin
         if (dpph_hit) dpph_reg <= DB_in;
         if (dppl_hit) dppl_reg <= DB_in;
         if (SHADOW != 0) begin
            // Commit forwards a same-cycle write so live never lags the CPU by a line.
            for (int i = 0; i < N_COLOR; i++) begin
               if (color_hit[i]) color_shd[i] <= DB_in;
               if (line_start)   color_reg[i] <= color_hit[i] ? DB_in : color_shd[i];
            end
            if (ctrl_hit)     ctrl_shd     <= DB_in;
            if (charbase_hit) charbase_shd <= DB_in;
            if (line_start) begin
               ctrl_reg     <= ctrl_hit     ? DB_in : ctrl_shd;
               charbase_reg <= charbase_hit ? DB_in : charbase_shd;
            end
         end else begin
            for (int i = 0; i < N_COLOR; i++) begin
               if (color_hit[i]) color_reg[i] <= DB_in;
            end
            if (ctrl_hit)     ctrl_reg     <= DB_in;
            if (charbase_hit) charbase_reg <= DB_in;
         end
      end
   end

   always_comb begin
      rd_data_next = '0;
      if (AB == OFF_MSTAT) begin
         rd_data_next = status_read;
      end else if (READBACK != 0) begin
         case (AB)
            OFF_DPPH:     rd_data_next = dpph_reg;
            OFF_DPPL:     rd_data_next = dppl_reg;
            OFF_CHARBASE: rd_data_next = charbase_reg;
            OFF_CTRL:     rd_data_next = ctrl_reg;
            default: begin
               for (int i = 0; i < N_COLOR; i++) begin
                  if (AB == color_offset(i)) rd_data_next = color_reg[i];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (srst) begin
         db_out_reg <= '0;
      end else if (rd_stb) begin
         db_out_reg <= rd_data_next;
      end
   end

   maria_wsync_fsm #(
      .WSYNC_MAX (WSYNC_MAX)
   ) u_wsync (
      .clk_sys    (clk_sys),
      .srst       (srst),
      .wsync_wr   (wsync_hit),
      .line_start (line_start),
      .ready      (ready)
   );

   assign DB_out    = db_out_reg;
   assign ctrl      = ctrl_reg;
   assign char_base = charbase_reg;
   assign ZP        = {dpph_reg, dppl_reg};

endmodule

// File: tb/tb_maria_regbank.sv
// Bench for maria_regbank: two configurations driven in lockstep, checked against an offset-indexed model.
module tb_maria_regbank;

   localparam int NP_A   = 2;
   localparam int NP_B   = 8;
   localparam int NC_A   = 1 + 3 * NP_A;
   localparam int NC_B   = 1 + 3 * NP_B;
   localparam int WMAX_A = 15;
   localparam int WMAX_B = 1023;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        maria_en = 1'b1;
   logic        bypass_bios = 1'b1;
   logic        pal = 1'b1;
   logic        pclk0 = 1'b0;
   logic        cs_maria = 1'b0;
   logic [4:0]  AB = '0;
   logic        RW = 1'b1;
   logic [7:0]  DB_in = '0;
   logic [7:0]  status_read = '0;
   logic        line_start = 1'b0;

   logic [7:0]  db_out_a, ctrl_a, cb_a, db_out_b, ctrl_b, cb_b;
   logic        ready_a, ready_b;
   logic [15:0] zp_a, zp_b;
   logic [7:0]  cm_a [NC_A];
   logic [7:0]  cm_b [NC_B];

   always #5 clk_sys = ~clk_sys;

   maria_regbank #(.N_PAL(NP_A), .SHADOW(0), .READBACK(1), .WSYNC_MAX(WMAX_A)) dut_a (
      .clk_sys(clk_sys), .reset(reset), .maria_en(maria_en), .bypass_bios(bypass_bios), .pal(pal),
      .pclk0(pclk0), .cs_maria(cs_maria), .AB(AB), .RW(RW), .DB_in(DB_in), .DB_out(db_out_a),
      .status_read(status_read), .line_start(line_start), .ready(ready_a), .ctrl(ctrl_a),
      .char_base(cb_a), .ZP(zp_a), .color_map(cm_a));

   maria_regbank #(.N_PAL(NP_B), .SHADOW(1), .READBACK(0), .WSYNC_MAX(WMAX_B)) dut_b (
      .clk_sys(clk_sys), .reset(reset), .maria_en(maria_en), .bypass_bios(bypass_bios), .pal(pal),
      .pclk0(pclk0), .cs_maria(cs_maria), .AB(AB), .RW(RW), .DB_in(DB_in), .DB_out(db_out_b),
      .status_read(status_read), .line_start(line_start), .ready(ready_b), .ctrl(ctrl_b),
      .char_base(cb_b), .ZP(zp_b), .color_map(cm_b));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: one byte per window offset (live and shadow), plus WSYNC wait flag and elapsed count.
   int         m_npal   [2] = '{NP_A, NP_B};
   int         m_shadow [2] = '{0, 1};
   int         m_rb     [2] = '{1, 0};
   int         m_wmax   [2] = '{WMAX_A, WMAX_B};
   logic [7:0] m_live [2][32];
   logic [7:0] m_shd  [2][32];
   logic [7:0] m_dbo  [2];
   bit         m_wait [2];
   int         m_cnt  [2];

   function automatic bit writable(input int d, input int off);
      if (off % 4 != 0) return (off / 4) < m_npal[d];
      return (off == 0) || (off == 12) || (off == 16) || (off == 20) || (off == 28);
   endfunction

   function automatic bit shadowed(input int off);
      return (off % 4 != 0) || (off == 0) || (off == 20) || (off == 28);
   endfunction

   function automatic int idx_of(input int off);
      if (off == 0) return 0;
      return 1 + 3 * (off / 4) + (off % 4) - 1;
   endfunction

   always @(posedge clk_sys) begin : model
      logic [15:0] zp;
      bit wr, rd;
      int o;
      for (int d = 0; d < 2; d++) begin
         if (reset || !maria_en) begin
            zp = bypass_bios ? (pal ? 16'h2730 : 16'h0084) : 16'h0000;
            for (int k = 0; k < 32; k++) m_live[d][k] = 8'h00;
            m_live[d][28] = 8'h70;
            m_live[d][12] = zp[15:8];
            m_live[d][16] = zp[7:0];
            for (int k = 0; k < 32; k++) m_shd[d][k] = m_live[d][k];
            m_wait[d] = 1'b0;
            m_cnt[d]  = 0;
            m_dbo[d]  = 8'h00;
         end else begin
            wr = pclk0 && cs_maria && !RW;
            rd = pclk0 && cs_maria && RW;
            o  = int'(AB);
            if (m_wait[d]) begin
               if (line_start) m_wait[d] = 1'b0;
               else begin
                  m_cnt[d]++;
                  if (m_cnt[d] >= m_wmax[d]) m_wait[d] = 1'b0;
               end
            end else if (wr && o == 4) begin
               m_wait[d] = 1'b1;
               m_cnt[d]  = 0;
            end
            if (rd) m_dbo[d] = (o == 8) ? status_read :
                               ((m_rb[d] != 0) && writable(d, o)) ? m_live[d][o] : 8'h00;
            if (wr && writable(d, o)) begin
               if ((m_shadow[d] != 0) && shadowed(o)) m_shd[d][o] = DB_in;
               else m_live[d][o] = DB_in;
            end
            if ((m_shadow[d] != 0) && line_start)
               for (int k = 0; k < 32; k++) if (shadowed(k)) m_live[d][k] = m_shd[d][k];
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (chk_en) begin
         chk("A.ready",  16'(ready_a),  16'(!m_wait[0]));
         chk("B.ready",  16'(ready_b),  16'(!m_wait[1]));
         chk("A.DB_out", 16'(db_out_a), 16'(m_dbo[0]));
         chk("B.DB_out", 16'(db_out_b), 16'(m_dbo[1]));
         chk("A.ctrl",   16'(ctrl_a),   16'(m_live[0][28]));
         chk("B.ctrl",   16'(ctrl_b),   16'(m_live[1][28]));
         chk("A.char_base", 16'(cb_a),  16'(m_live[0][20]));
         chk("B.char_base", 16'(cb_b),  16'(m_live[1][20]));
         chk("A.ZP", zp_a, {m_live[0][12], m_live[0][16]});
         chk("B.ZP", zp_b, {m_live[1][12], m_live[1][16]});
         for (int o = 0; o < 32; o++) begin
            if (o == 0 || (o % 4 != 0 && o / 4 < NP_A))
               chk($sformatf("A.color_map[%0d]", idx_of(o)), 16'(cm_a[idx_of(o)]), 16'(m_live[0][o]));
            if (o == 0 || (o % 4 != 0 && o / 4 < NP_B))
               chk($sformatf("B.color_map[%0d]", idx_of(o)), 16'(cm_b[idx_of(o)]), 16'(m_live[1][o]));
         end
      end
   end

   task automatic acc(input bit is_rd, input logic [4:0] a, input logic [7:0] d, input bit ls);
      pclk0 = 1'b1; cs_maria = 1'b1; RW = is_rd; AB = a; DB_in = d; line_start = ls;
      @(negedge clk_sys);
      pclk0 = 1'b0; cs_maria = 1'b0; RW = 1'b1; line_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic pulse_ls();
      line_start = 1'b1;
      @(negedge clk_sys);
      line_start = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_sys);
      chk_en = 1'b1;
      chk("lit.reset.A.ctrl", 16'(ctrl_a), 16'h0070);
      chk("lit.reset.A.ZP", zp_a, 16'h2730);
      chk("lit.reset.B.ZP", zp_b, 16'h2730);
      chk("lit.reset.A.ready", 16'(ready_a), 16'h0001);
      chk("lit.reset.B.color24", 16'(cm_b[24]), 16'h0000);
      reset = 1'b0;

      acc(1'b0, 5'h06, 8'h5A, 1'b0);
      chk("lit.A.color5", 16'(cm_a[5]), 16'h005A);
      chk("lit.B.color5_shadowed", 16'(cm_b[5]), 16'h0000);
      acc(1'b0, 5'h0D, 8'h77, 1'b0);
      acc(1'b1, 5'h0D, 8'h00, 1'b0);
      chk("lit.A.read_unmapped_pal", 16'(db_out_a), 16'h0000);

      acc(1'b0, 5'h1C, 8'h40, 1'b0);
      chk("lit.B.ctrl_shadowed", 16'(ctrl_b), 16'h0070);
      chk("lit.A.ctrl_live", 16'(ctrl_a), 16'h0040);
      pulse_ls();
      chk("lit.B.ctrl_commit", 16'(ctrl_b), 16'h0040);
      chk("lit.B.color5_commit", 16'(cm_b[5]), 16'h005A);
      acc(1'b0, 5'h00, 8'h11, 1'b1);
      chk("lit.B.bg_forward", 16'(cm_b[0]), 16'h0011);

      acc(1'b0, 5'h10, 8'h84, 1'b0);
      acc(1'b1, 5'h10, 8'h00, 1'b0);
      chk("lit.A.read_dppl", 16'(db_out_a), 16'h0084);
      chk("lit.B.read_no_readback", 16'(db_out_b), 16'h0000);
      status_read = 8'h80;
      acc(1'b1, 5'h08, 8'h00, 1'b0);
      chk("lit.A.mstat", 16'(db_out_a), 16'h0080);
      chk("lit.B.mstat", 16'(db_out_b), 16'h0080);

      cs_maria = 1'b1; RW = 1'b0; AB = 5'h14; DB_in = 8'hEE; pclk0 = 1'b0;
      @(negedge clk_sys);
      cs_maria = 1'b0; RW = 1'b1;
      chk("lit.A.pclk0_gate", 16'(cb_a), 16'h0000);

      acc(1'b0, 5'h04, 8'h00, 1'b0);
      chk("lit.A.wsync_fall", 16'(ready_a), 16'h0000);
      chk("lit.B.wsync_fall", 16'(ready_b), 16'h0000);
      idle(14);
      chk("lit.A.wsync_before_timeout", 16'(ready_a), 16'h0000);
      idle(1);
      chk("lit.A.wsync_timeout", 16'(ready_a), 16'h0001);
      idle(34);
      chk("lit.B.wsync_still_wait", 16'(ready_b), 16'h0000);
      pulse_ls();
      chk("lit.B.wsync_line_release", 16'(ready_b), 16'h0001);

      acc(1'b0, 5'h04, 8'h00, 1'b1);
      chk("lit.A.wsync_coincident", 16'(ready_a), 16'h0000);
      idle(5);
      acc(1'b0, 5'h04, 8'h00, 1'b0);
      idle(8);
      chk("lit.A.wsync_no_restart_hold", 16'(ready_a), 16'h0000);
      idle(1);
      chk("lit.A.wsync_no_restart_release", 16'(ready_a), 16'h0001);
      pulse_ls();

      for (int o = 0; o < 32; o++) acc(1'b0, 5'(o), 8'(o) ^ 8'hA5, 1'b0);
      pulse_ls();
      for (int o = 0; o < 32; o++) acc(1'b1, 5'(o), 8'h00, 1'b0);
      pulse_ls();

      acc(1'b0, 5'h04, 8'h00, 1'b0);
      idle(3);
      pal = 1'b0; maria_en = 1'b0;
      @(negedge clk_sys);
      chk("lit.A.en_drop_ready", 16'(ready_a), 16'h0001);
      chk("lit.B.en_drop_ready", 16'(ready_b), 16'h0001);
      chk("lit.A.en_drop_ctrl", 16'(ctrl_a), 16'h0070);
      chk("lit.A.en_drop_ZP", zp_a, 16'h0084);
      chk("lit.A.en_drop_color5", 16'(cm_a[5]), 16'h0000);
      maria_en = 1'b1; bypass_bios = 1'b0; reset = 1'b1;
      @(negedge clk_sys);
      chk("lit.B.no_bypass_ZP", zp_b, 16'h0000);
      reset = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
